// File: rtl/adder_err_eval.sv
// Error-evaluation harness for a 16-bit approximate adder: drives operand pairs,
// checks each returned sum against the exact sum and accumulates error statistics.
module adder_err_eval #(
  parameter int          WIDTH   = 16,
  parameter int          CNT_W   = 16,
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter int          TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [CNT_W-1:0]       num_samples,
  output logic [WIDTH-1:0]       op_a,
  output logic [WIDTH-1:0]       op_b,
  output logic                   op_valid,
  input  logic [WIDTH:0]         res_sum,
  input  logic                   res_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [CNT_W-1:0]       err_count,
  output logic [WIDTH:0]         max_ed,
  output logic [WIDTH+CNT_W:0]   sum_ed
);

  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int          TO_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          g_q, g_d;
  logic                 mode_q, mode_d;
  logic [CNT_W-1:0]     nsamp_q, nsamp_d;
  logic [CNT_W-1:0]     scnt_q, scnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [WIDTH:0]       res_q, res_d;
  logic [CNT_W-1:0]     err_count_q, err_count_d;
  logic [WIDTH:0]       max_ed_q, max_ed_d;
  logic [WIDTH+CNT_W:0] sum_ed_q, sum_ed_d;
  logic                 timeout_q, timeout_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 op_valid_q, op_valid_d;

  logic [WIDTH:0]       exact;
  logic [WIDTH:0]       ed;
  logic [31:0]          lfsr_next;

  assign op_a      = g_q[31 -: WIDTH];
  assign op_b      = g_q[WIDTH-1:0];
  assign op_valid  = op_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign err_count = err_count_q;
  assign max_ed    = max_ed_q;
  assign sum_ed    = sum_ed_q;

  // Operands are only read in CHECK, where they still hold the sample just driven.
  assign exact     = {1'b0, op_a} + {1'b0, op_b};
  assign ed        = (exact >= res_q) ? (exact - res_q) : (res_q - exact);
  assign lfsr_next = g_q[0] ? ((g_q >> 1) ^ LFSR_MASK) : (g_q >> 1);

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    mode_d      = mode_q;
    nsamp_d     = nsamp_q;
    scnt_d      = scnt_q;
    to_cnt_d    = to_cnt_q;
    res_d       = res_q;
    err_count_d = err_count_q;
    max_ed_d    = max_ed_q;
    sum_ed_d    = sum_ed_q;
    timeout_d   = timeout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mode_d      = mode;
          nsamp_d     = num_samples;
          scnt_d      = '0;
          to_cnt_d    = '0;
          err_count_d = '0;
          max_ed_d    = '0;
          sum_ed_d    = '0;
          timeout_d   = 1'b0;
          g_d         = mode ? SEED_EFF : 32'd0;
          state_d     = (num_samples == '0) ? DONE : DRIVE;
        end
      end
      DRIVE: begin
        if (res_valid) begin
          res_d    = res_sum;
          to_cnt_d = '0;
          state_d  = CHECK;
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d  = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      CHECK: begin
        if (ed != '0) err_count_d = err_count_q + CNT_W'(1);
        if (ed > max_ed_q) max_ed_d = ed;
        sum_ed_d = sum_ed_q + {{CNT_W{1'b0}}, ed};
        scnt_d   = scnt_q + CNT_W'(1);
        if (scnt_d == nsamp_q) begin
          state_d = DONE;
        end else begin
          g_d     = mode_q ? lfsr_next : (g_q + 32'd1);
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs follow the next state so they are registered with it.
    op_valid_d = (state_d == DRIVE);
    busy_d     = (state_d == DRIVE) || (state_d == CHECK);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      mode_q      <= 1'b0;
      nsamp_q     <= '0;
      scnt_q      <= '0;
      to_cnt_q    <= '0;
      res_q       <= '0;
      err_count_q <= '0;
      max_ed_q    <= '0;
      sum_ed_q    <= '0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      op_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      mode_q      <= mode_d;
      nsamp_q     <= nsamp_d;
      scnt_q      <= scnt_d;
      to_cnt_q    <= to_cnt_d;
      res_q       <= res_d;
      err_count_q <= err_count_d;
      max_ed_q    <= max_ed_d;
      sum_ed_q    <= sum_ed_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      op_valid_q  <= op_valid_d;
    end
  end

endmodule

// File: doc/adder_err_eval.md
Name: adder_err_eval

Overview:
- Sequential error-evaluation harness for the other end of a 16-bit approximate adder: the side that drives operand pairs and consumes the 17-bit sum.
- Generates operand pairs by counter sweep or LFSR and presents them to an external adder under test (DUT).
- Captures the DUT sum and compares it against the exact A+B.
- Accumulates error statistics (error count, max error distance, sum of error distances) over a programmed sample count, then signals done.

Parameters:
- WIDTH, 16, operand width; the DUT result is WIDTH+1 bits.
- CNT_W, 16, width of the sample counter and err_count.
- SEED, 32'h0000_0001, LFSR seed for mode 1; must be nonzero (a value of 0 is replaced by 1).
- TIMEOUT, 64, maximum cycles to wait for res_valid per sample.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run when in IDLE or DONE
- mode  in  1  0 = counter sweep, 1 = LFSR random; sampled on start
- num_samples  in  CNT_W  samples per run; sampled on start
- op_a  out  WIDTH  operand A to DUT
- op_b  out  WIDTH  operand B to DUT
- op_valid  out  1  operands valid; DUT result requested
- res_sum  in  WIDTH+1  DUT sum, bit WIDTH = carry out
- res_valid  in  1  DUT result strobe; honoured only while op_valid=1
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- timeout  out  1  run aborted by missing res_valid
- err_count  out  CNT_W  samples with res_sum != exact
- max_ed  out  WIDTH+1  maximum |exact - res_sum|
- sum_ed  out  WIDTH+1+CNT_W  sum of |exact - res_sum|

Behaviour:

Reset:
- rst_n low forces all outputs and internal state to 0 asynchronously; the FSM enters IDLE.
- Reset mid-run aborts the run with no partial results retained.

FSM states: IDLE, DRIVE, CHECK, DONE.

IDLE / DONE:
- On start: latch mode and num_samples; clear err_count, max_ed, sum_ed, timeout, done and the sample counter.
- Load the generator: counter = 0, or LFSR = SEED.
- If num_samples == 0, go to DONE (done=1, stats 0). Otherwise go to DRIVE.

Generator:
- Holds a 32-bit state G; op_a = G[31:16], op_b = G[15:0].
- Mode 0: G increments by 1 per sample, wrapping at 2^32.
- Mode 1: Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shifted right with the mask applied when G[0]=1.
- Operands are registered and stable for the whole DRIVE state.

DRIVE:
- op_valid=1, busy=1; the timeout counter increments each cycle.
- res_valid=1: latch res_sum, go to CHECK, clear the timeout counter.
- Timeout counter reaches TIMEOUT with no res_valid: timeout=1, go to DONE; stats are left as accumulated so far.

CHECK:
- op_valid=0.
- exact = op_a + op_b, zero-extended to WIDTH+1 bits; ed = |exact - res_sum|, unsigned.
- If ed != 0: err_count += 1.
- max_ed = max(max_ed, ed); sum_ed += ed.
- Sample counter += 1. If it equals num_samples, go to DONE; otherwise advance G and go to DRIVE.

DONE:
- done=1, busy=0; results hold until the next start.

Handshake rules:
- At most one outstanding sample.
- res_valid outside DRIVE is ignored.
- start while busy is ignored.
- A start on the same cycle as the DONE entry is not seen; start is acted on in DONE from the next cycle.

Throughput and latency:
- 2 cycles per sample when the DUT responds in the same cycle (res_valid = op_valid).
- Total run with such a DUT: 1 + 2*N cycles from start to done.

Widths:
- No overflow is possible: sum_ed max is (2^(WIDTH+1)-1)*(2^CNT_W-1).
- err_count ≤ num_samples.

Test Plan:
- Exact loopback DUT (res_sum = op_a+op_b, res_valid = op_valid), mode 0, num_samples=100 -> done at cycle 201 after start; err_count=0, max_ed=0, sum_ed=0, timeout=0.
- DUT forces res_sum[0]=0, mode 0, num_samples=4 (a=0, b=0..3; exact 0,1,2,3; DUT 0,0,2,2) -> err_count=2, max_ed=1, sum_ed=2.
- DUT forces res_sum[3:0]=0, mode 1, SEED=1, num_samples=1000 -> statistics match a reference model fed by the same LFSR; max_ed ≤ 15.
- DUT never asserts res_valid, TIMEOUT=8 -> timeout=1, done=1, busy=0 after 1+8 cycles; err_count=0.
- num_samples=0 -> done=1 on the cycle after start, op_valid never asserted. A second start pulse during busy is ignored.
- rst_n asserted during DRIVE of sample 50 -> all outputs 0 immediately. After release, a new start runs cleanly from G=0.
